// File: rtl/event_encoder.sv
// Edge-triggered request encoder: rising edges on I are queued as pending bits and
// handed out one index at a time through a valid/ready slot (fixed priority or round-robin).
module event_encoder #(
  parameter int N    = 10,
  parameter int MODE = 0,
  localparam int W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] I,
  input  logic         clr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] Y,
  output logic [W:0]   pend_cnt,
  output logic         overflow
);

  logic [N-1:0]   i_q;
  logic [N-1:0]   pend;
  logic [N-1:0]   edge_vec;
  logic [N-1:0]   grant;
  logic [N-1:0]   rot;
  logic [2*N-1:0] dbl;
  logic [W-1:0]   last;
  logic [W-1:0]   base;
  logic [W-1:0]   sel_idx;
  logic           sel_found;
  logic           load;
  int             off;
  int             sum;

  assign edge_vec = I & ~i_q;
  assign load     = !out_valid || out_ready;

  // Round-robin rotates pending so the search start lands at bit 0, then takes the lowest set bit.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    base      = (last == W'(N - 1)) ? '0 : last + 1'b1;
    dbl       = '0;
    rot       = '0;
    off       = 0;
    sum       = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          sel_idx   = W'(i);
          sel_found = 1'b1;
        end
      end
    end else begin
      dbl = {pend, pend} >> base;
      rot = dbl[N-1:0];
      for (int i = N - 1; i >= 0; i--) begin
        if (rot[i]) begin
          off       = i;
          sel_found = 1'b1;
        end
      end
      sum = int'(base) + off;
      if (sum >= N) sum = sum - N;
      sel_idx = W'(sum);
    end
  end

  always_comb begin
    grant = '0;
    if (load && sel_found) grant[sel_idx] = 1'b1;
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N; i++) pend_cnt = pend_cnt + {{W{1'b0}}, pend[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q       <= '0;
      pend      <= '0;
      out_valid <= 1'b0;
      Y         <= '0;
      overflow  <= 1'b0;
      last      <= W'(N - 1);
    end else if (clr) begin
      i_q       <= I;
      pend      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      last      <= W'(N - 1);
    end else begin
      i_q  <= I;
      // A fresh edge on the bit granted this cycle re-arms it rather than being lost.
      pend <= (pend & ~grant) | edge_vec;
      if (|(edge_vec & pend & ~grant)) overflow <= 1'b1;
      if (load) begin
        out_valid <= sel_found;
        if (sel_found) begin
          Y    <= sel_idx;
          last <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder: runs a fixed-priority and a round-robin instance side by side
// on shared stimulus, against directed expectations and a behavioural model.
module tb_event_encoder;
  localparam int N = 10;
  localparam int W = 4;

  logic         clk, reset, clr, out_ready;
  logic [N-1:0] I;
  logic         v0, v1, ov0, ov1;
  logic [W-1:0] y0, y1;
  logic [W:0]   pc0, pc1;

  int checks = 0;
  int errors = 0;

  event_encoder #(.N(N), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .I(I), .clr(clr), .out_ready(out_ready),
    .out_valid(v0), .Y(y0), .pend_cnt(pc0), .overflow(ov0));

  event_encoder #(.N(N), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .I(I), .clr(clr), .out_ready(out_ready),
    .out_valid(v1), .Y(y1), .pend_cnt(pc1), .overflow(ov1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending set of request indices, a slot, and a priority search.
  logic [N-1:0] m_p [2];
  logic         m_v [2];
  logic         m_ovf [2];
  int           m_y [2];
  int           m_last [2];
  logic [N-1:0] m_iq;

  always @(posedge clk or posedge reset) begin : model_b
    logic [N-1:0] e, p;
    logic v, o;
    int g, y, l;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_p[m] <= '0; m_v[m] <= 1'b0; m_ovf[m] <= 1'b0; m_y[m] <= 0; m_last[m] <= N - 1;
      end
      m_iq <= '0;
    end else begin
      e = I & ~m_iq;
      for (int m = 0; m < 2; m++) begin
        p = m_p[m]; v = m_v[m]; o = m_ovf[m]; y = m_y[m]; l = m_last[m];
        if (clr) begin
          p = '0; v = 1'b0; o = 1'b0; l = N - 1;
        end else begin
          g = -1;
          if (!v || out_ready) begin
            if (m == 0) begin
              for (int j = N - 1; j >= 0; j--) if (g < 0 && p[j]) g = j;
            end else begin
              for (int s = 1; s <= N; s++) if (g < 0 && p[(l + s) % N]) g = (l + s) % N;
            end
            if (g >= 0) begin v = 1'b1; y = g; l = g; end
            else v = 1'b0;
          end
          for (int j = 0; j < N; j++) if (e[j] && p[j] && j != g) o = 1'b1;
          if (g >= 0) p[g] = 1'b0;
          p = p | e;
        end
        m_p[m] <= p; m_v[m] <= v; m_ovf[m] <= o; m_y[m] <= y; m_last[m] <= l;
      end
      m_iq <= I;
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({v0, y0, pc0, ov0} !== '0 || {v1, y1, pc1, ov1} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%0b/%0b Y=%0d/%0d pc=%0d/%0d ov=%0b/%0b want all 0",
               v0, v1, y0, y1, pc0, pc1, ov0, ov1);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    I = 10'b0000001000;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || pc0 !== 5'd1) begin
      errors++; $display("FAIL single_detect got v=%0b pc=%0d want v=0 pc=1", v0, pc0);
    end
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || y0 !== 4'd3 || v1 !== 1'b1 || y1 !== 4'd3) begin
      errors++; $display("FAIL single_grant got v=%0b Y=%0d / v=%0b Y=%0d want v=1 Y=3", v0, y0, v1, y1);
    end
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || pc0 !== 5'd0) begin
      errors++; $display("FAIL single_drain got v=%0b pc=%0d want v=0 pc=0", v0, pc0);
    end
    I = '0;
    @(negedge clk);
  endtask

  task automatic test_priority_modes();
    int e0 [3] = '{9, 7, 2};
    int e1 [3] = '{2, 7, 9};
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    I = 10'b1010000100;
    @(negedge clk);
    checks++;
    if (pc0 !== 5'd3 || pc1 !== 5'd3 || v0 !== 1'b0) begin
      errors++; $display("FAIL burst_pend got pc=%0d/%0d v=%0b want 3/3 v=0", pc0, pc1, v0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (v0 !== 1'b1 || int'(y0) != e0[c] || int'(pc0) != 2 - c) begin
        errors++; $display("FAIL fixed_seq%0d got v=%0b Y=%0d pc=%0d want Y=%0d pc=%0d", c, v0, y0, pc0, e0[c], 2 - c);
      end
      checks++;
      if (v1 !== 1'b1 || int'(y1) != e1[c] || int'(pc1) != 2 - c) begin
        errors++; $display("FAIL rr_seq%0d got v=%0b Y=%0d pc=%0d want Y=%0d pc=%0d", c, v1, y1, pc1, e1[c], 2 - c);
      end
    end
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++; $display("FAIL burst_idle got v=%0b/%0b want 0/0", v0, v1);
    end
    I = 10'b0100000001;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (y1 !== 4'd0 || v1 !== 1'b1 || y0 !== 4'd8 || v0 !== 1'b1) begin
      errors++; $display("FAIL wrap_first got rr Y=%0d fixed Y=%0d want rr 0 fixed 8", y1, y0);
    end
    @(negedge clk);
    checks++;
    if (y1 !== 4'd8 || v1 !== 1'b1 || y0 !== 4'd0 || v0 !== 1'b1) begin
      errors++; $display("FAIL wrap_second got rr Y=%0d fixed Y=%0d want rr 8 fixed 0", y1, y0);
    end
    I = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    I = 10'b0000100000;
    out_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (v0 !== 1'b1 || y0 !== 4'd5 || v1 !== 1'b1 || y1 !== 4'd5) begin
        errors++; $display("FAIL hold%0d got v=%0b Y=%0d / v=%0b Y=%0d want v=1 Y=5", c, v0, y0, v1, y1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++; $display("FAIL accept got v=%0b/%0b want 0/0", v0, v1);
    end
    I = '0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    I = 10'b1000000000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || y0 !== 4'd9 || v1 !== 1'b1 || y1 !== 4'd9) begin
      errors++; $display("FAIL ovf_slot got Y=%0d/%0d want 9", y0, y1);
    end
    I = 10'b1000010000;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || pc0 !== 5'd1) begin
      errors++; $display("FAIL ovf_first got ov=%0b pc=%0d want ov=0 pc=1", ov0, pc0);
    end
    I = 10'b1000000000;
    @(negedge clk);
    I = 10'b1000010000;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1 || ov1 !== 1'b1 || pc0 !== 5'd1 || pc1 !== 5'd1 || y0 !== 4'd9) begin
      errors++; $display("FAIL ovf_set got ov=%0b/%0b pc=%0d/%0d Y=%0d want ov=1 pc=1 Y=9", ov0, ov1, pc0, pc1, y0);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || v0 !== 1'b0 || pc0 !== 5'd0 || ov1 !== 1'b0 || v1 !== 1'b0 || pc1 !== 5'd0) begin
      errors++; $display("FAIL clr_flush got ov=%0b v=%0b pc=%0d want all 0", ov0, v0, pc0);
    end
    @(negedge clk);
    checks++;
    if (pc0 !== 5'd0 || v0 !== 1'b0) begin
      errors++; $display("FAIL clr_noedge got pc=%0d v=%0b want 0 0", pc0, v0);
    end
    I = '0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    I = 10'b0000001110;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || pc0 !== 5'd2 || v1 !== 1'b1 || pc1 !== 5'd2) begin
      errors++; $display("FAIL pre_reset got v=%0b pc=%0d want v=1 pc=2", v0, pc0);
    end
    #2;
    reset = 1'b1;
    I = 10'b0000000001;
    #1;
    checks++;
    if ({v0, y0, pc0, ov0} !== '0 || {v1, y1, pc1, ov1} !== '0) begin
      errors++; $display("FAIL async_reset got v=%0b Y=%0d pc=%0d ov=%0b want all 0", v0, y0, pc0, ov0);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || pc0 !== 5'd1) begin
      errors++; $display("FAIL release_edge got v=%0b pc=%0d want v=0 pc=1", v0, pc0);
    end
    @(negedge clk);
    checks++;
    if (v0 !== 1'b1 || y0 !== 4'd0 || v1 !== 1'b1 || y1 !== 4'd0) begin
      errors++; $display("FAIL release_grant got Y=%0d/%0d v=%0b want Y=0 v=1", y0, y1, v0);
    end
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || pc0 !== 5'd0) begin
      errors++; $display("FAIL no_replay got v=%0b/%0b pc=%0d want 0", v0, v1, pc0);
    end
    I = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (v0 !== m_v[0] || y0 !== 4'(m_y[0]) || int'(pc0) != $countones(m_p[0]) || ov0 !== m_ovf[0]) begin
        errors++;
        $display("FAIL rand_fixed c=%0d got v=%0b Y=%0d pc=%0d ov=%0b want v=%0b Y=%0d pc=%0d ov=%0b",
                 c, v0, y0, pc0, ov0, m_v[0], m_y[0], $countones(m_p[0]), m_ovf[0]);
      end
      checks++;
      if (v1 !== m_v[1] || y1 !== 4'(m_y[1]) || int'(pc1) != $countones(m_p[1]) || ov1 !== m_ovf[1]) begin
        errors++;
        $display("FAIL rand_rr c=%0d got v=%0b Y=%0d pc=%0d ov=%0b want v=%0b Y=%0d pc=%0d ov=%0b",
                 c, v1, y1, pc1, ov1, m_v[1], m_y[1], $countones(m_p[1]), m_ovf[1]);
      end
      checks++;
      if (int'(y0) >= N || int'(y1) >= N) begin
        errors++; $display("FAIL rand_range c=%0d got Y=%0d/%0d want < %0d", c, y0, y1, N);
      end
      mask = '0;
      for (int j = 0; j < N; j++) mask[j] = ($urandom_range(0, 99) < 15);
      I = I ^ mask;
      out_ready = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 99) < 3);
    end
    clr = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clr = 1'b0;
    out_ready = 1'b1;
    I = '0;
    test_reset();
    test_single();
    test_priority_modes();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter N, default 10: number of request inputs; legal range 2..64.
REQ-002 Parameter MODE, default 0: 0 = fixed priority (highest index first); 1 = round-robin.
REQ-003 Derived constant W = max(1, ceil(log2 N)): index width. It is not user-overridable.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset of all state.
REQ-006 I  input  N  request lines; a request is a rising edge, not a level.
REQ-007 clr  input  1  synchronous flush of pending, output and error state.
REQ-008 out_ready  input  1  consumer accepts Y this cycle.
REQ-009 out_valid  output  1  Y holds a granted index.
REQ-010 Y  output  W  binary index of the granted request.
REQ-011 pend_cnt  output  W+1  popcount of the pending register.
REQ-012 overflow  output  1  sticky error: a request was lost.

Function
REQ-013 A registered copy I_q of I shall be kept. The edge vector is E = I & ~I_q, evaluated at each clock edge.
REQ-014 The pending register P[N-1:0] shall update as P <= (P & ~G) | E, where G is the one-hot grant loaded this cycle (0 if no load).
- A new edge on a bit granted in the same cycle sets that bit again.
REQ-015 The output slot loads when out_valid == 0, or when out_valid && out_ready.
- If P != 0 at a load: select index k per MODE, set Y <= k, out_valid <= 1, G = onehot(k).
- If P == 0 at a load: out_valid <= 0 and Y is held.
REQ-016 MODE 0 shall grant the highest set index of P.
REQ-017 MODE 1 shall grant the first set bit of P, searching from (last + 1) mod N upward with wrap-around.
- last is the register holding the most recently granted index; reset value N-1, so the first search starts at bit 0.
REQ-018 Selection shall use P as it was before this cycle's edges are OR-ed in. Latency from the clock edge detecting E[j] to out_valid with Y=j is therefore one cycle minimum, when the slot is free and j wins.
REQ-019 Y and out_valid shall remain stable while out_valid && !out_ready.
REQ-020 overflow shall be set when E[j] && P[j] && !G[j] for any j. It stays set until clr or reset.
REQ-021 pend_cnt shall equal popcount(P) of the registered P, with range 0..N.
REQ-022 clr shall override everything else in the same cycle.
- Clears: P, out_valid, overflow; sets last to N-1; loads I_q <= I.
- Edges present in that cycle are discarded.
REQ-023 Y at index N-1 and N not a power of two: indices >= N shall never appear on Y.

Reset
REQ-024 While reset is high, with no clock required: P=0, I_q=0, out_valid=0, Y=0, pend_cnt=0, overflow=0, last=N-1.
REQ-025 Because I_q resets to 0, any I bit still high at reset release counts as an edge on the first clock edge.
REQ-026 Reset asserted mid-transfer shall drop the pending and in-flight grants; no grant is replayed after release.

Verification (N=10)
REQ-027 MODE0, idle. I goes 0 -> 10'b0000001000 at edge k, out_ready=1.
- Edge k+1: out_valid=1, Y=3.
- Edge k+2: out_valid=0, pend_cnt=0.
REQ-028 MODE0. Edges on bits 2, 7, 9 at the same edge, out_ready=1.
- Y sequence 9, 7, 2 on consecutive cycles.
- pend_cnt 3, 2, 1, 0.
REQ-029 MODE1. Same stimulus gives Y sequence 2, 7, 9.
- Then an edge on bits 0 and 8 while 9 is last gives Y 0, then 8.
REQ-030 Backpressure. Single request 5 with out_ready=0 for 5 cycles.
- Y=5 and out_valid=1 stable throughout.
- Acceptance on the 6th cycle, then out_valid=0.
REQ-031 Overflow. With out_ready=0 and bit 9 occupying the slot, bit 4 rises, falls, then rises again.
- Result: overflow=1 and pend_cnt=1.
- clr pulse: overflow=0, out_valid=0, pend_cnt=0 on the next edge.
REQ-032 Async reset. Assert reset between clock edges while out_valid=1, pend_cnt=2.
- All outputs go to 0 immediately.
- After release, I held at 10'b0000000001 yields Y=0 one cycle after the first edge.
